// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding and default widths for the PC sequencer
package pc_pkg;

    localparam int PC_W  = 12;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - run-control and branch-target bundle between the top level and the PC sequencer
interface pc_sequencer_if #(
    parameter int D  = pc_pkg::PC_W,
    parameter int CW = pc_pkg::CNT_W
);
    logic          start;
    logic [D-1:0]  start_addr;
    logic          branch_en;
    logic          branch_taken;
    logic [D-1:0]  target;
    logic          halt_req;
    logic [D-1:0]  prog_ctr;
    logic          running;
    logic          done;
    logic [CW-1:0] instr_count;
    logic          pc_fault;

    modport master (
        output start, start_addr, branch_en, branch_taken, target, halt_req,
        input  prog_ctr, running, done, instr_count, pc_fault
    );

    modport slave (
        input  start, start_addr, branch_en, branch_taken, target, halt_req,
        output prog_ctr, running, done, instr_count, pc_fault
    );
endinterface

// File: rtl/pc_sequencer_next_calc.sv
// rtl/pc_sequencer_next_calc.sv - next fetch address: +1 or signed branch offset, with range flag
import pc_pkg::*;

module pc_next_calc #(
    parameter int D = PC_W
) (
    input  logic [D-1:0] prog_ctr,
    input  logic [D-1:0] target,
    input  logic         sel_branch,
    output logic [D-1:0] next_pc,
    output logic         out_of_range
);

    logic [D:0] sum;

    // With an unsigned PC and a signed offset, bit D of the D+1-bit sum is set exactly
    // when the true result is negative or above 2^D-1, and also on the 2^D-1 -> 0 step.
    always_comb begin
        if (sel_branch) begin
            sum = {1'b0, prog_ctr} + {target[D-1], target};
        end else begin
            sum = {1'b0, prog_ctr} + {{D{1'b0}}, 1'b1};
        end
    end

    assign next_pc      = sum[D-1:0];
    assign out_of_range = sum[D];

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer: run/halt FSM, instruction counter, sticky PC fault
import pc_pkg::*;

module pc_sequencer #(
    parameter int D  = PC_W,
    parameter int CW = CNT_W
) (
    input  logic                Clk,
    input  logic                Reset,
    pc_sequencer_if.slave       bus
);

    pc_state_t     state, state_n;
    logic [D-1:0]  pc_q, pc_n;
    logic [CW-1:0] cnt_q, cnt_n, cnt_inc;
    logic          fault_q, fault_n;
    logic          running_q, done_q;

    logic          sel_branch;
    logic [D-1:0]  calc_pc;
    logic          calc_oor;

    assign sel_branch = bus.branch_en & bus.branch_taken;
    assign cnt_inc    = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    pc_next_calc #(.D(D)) u_next_calc (
        .prog_ctr     (pc_q),
        .target       (bus.target),
        .sel_branch   (sel_branch),
        .next_pc      (calc_pc),
        .out_of_range (calc_oor)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            pc_q      <= pc_n;
            cnt_q     <= cnt_n;
            fault_q   <= fault_n;
            running_q <= (state_n == RUN);
            done_q    <= (state_n == HALT);
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        cnt_n   = cnt_q;
        fault_n = fault_q;
        case (state)
            RUN: begin
                cnt_n = cnt_inc;
                if (bus.halt_req) begin
                    state_n = HALT;
                end else if (sel_branch && (bus.target == '0)) begin
                    // A taken zero-offset branch would spin forever; treat it as a fault stop.
                    fault_n = 1'b1;
                    state_n = HALT;
                end else begin
                    pc_n = calc_pc;
                    if (calc_oor) begin
                        fault_n = 1'b1;
                    end
                end
            end
            IDLE, HALT: begin
                if (bus.start) begin
                    pc_n    = bus.start_addr;
                    cnt_n   = '0;
                    fault_n = 1'b0;
                    state_n = RUN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.prog_ctr    = pc_q;
    assign bus.instr_count = cnt_q;
    assign bus.pc_fault    = fault_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer (D=12, CW=16)
module tb_pc_sequencer;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_pass;

    pc_sequencer_if #(.D(12), .CW(16)) bus ();

    pc_sequencer #(.D(12), .CW(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start        = 1'b0;
        bus.start_addr   = '0;
        bus.branch_en    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.target       = '0;
        bus.halt_req     = 1'b0;
    endtask

    task automatic do_start(input logic [11:0] addr);
        idle_inputs();
        bus.start      = 1'b1;
        bus.start_addr = addr;
        tick();
        idle_inputs();
    endtask

    task automatic do_halt();
        idle_inputs();
        bus.halt_req = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic do_branch(input logic en, input logic taken, input logic [11:0] tgt);
        idle_inputs();
        bus.branch_en    = en;
        bus.branch_taken = taken;
        bus.target       = tgt;
        tick();
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        Reset = 1'b1;
        #2;
        check("rst_pc",      32'(bus.prog_ctr),    32'h000);
        check("rst_running", 32'(bus.running),     32'h0);
        check("rst_done",    32'(bus.done),        32'h0);
        check("rst_count",   32'(bus.instr_count), 32'h0);
        check("rst_fault",   32'(bus.pc_fault),    32'h0);
        tick();
        Reset = 1'b0;
        tick();

        // Idle ignores branch/halt inputs
        do_branch(1'b1, 1'b1, 12'h005);
        check("idle_hold_pc", 32'(bus.prog_ctr), 32'h000);
        check("idle_running", 32'(bus.running),  32'h0);

        do_start(12'h010);
        check("start_pc",      32'(bus.prog_ctr),    32'h010);
        check("start_running", 32'(bus.running),     32'h1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("seq_pc", 32'(bus.prog_ctr), 32'h010 + 32'(i));
        end
        check("seq_count",   32'(bus.instr_count), 32'd3);
        check("seq_running", 32'(bus.running),     32'h1);
        check("seq_done",    32'(bus.done),        32'h0);

        do_halt();
        check("halt_pc",    32'(bus.prog_ctr),    32'h013);
        check("halt_count", 32'(bus.instr_count), 32'd4);
        check("halt_done",  32'(bus.done),        32'h1);
        tick();
        check("halt_hold_pc", 32'(bus.prog_ctr), 32'h013);

        do_start(12'h100);
        do_branch(1'b1, 1'b1, 12'hF9B);
        check("br_neg_pc",    32'(bus.prog_ctr), 32'h09B);
        check("br_neg_fault", 32'(bus.pc_fault), 32'h0);
        do_halt();
        do_start(12'h100);
        do_branch(1'b1, 1'b0, 12'hF9B);
        check("br_nt_pc",    32'(bus.prog_ctr), 32'h101);
        check("br_nt_fault", 32'(bus.pc_fault), 32'h0);

        do_halt();
        do_start(12'h005);
        do_branch(1'b1, 1'b1, 12'hF9B);
        check("br_under_pc",      32'(bus.prog_ctr), 32'hFA0);
        check("br_under_fault",   32'(bus.pc_fault), 32'h1);
        check("br_under_running", 32'(bus.running),  32'h1);
        do_branch(1'b1, 1'b1, 12'h000);
        check("selfloop_pc",      32'(bus.prog_ctr), 32'hFA0);
        check("selfloop_done",    32'(bus.done),     32'h1);
        check("selfloop_running", 32'(bus.running),  32'h0);
        check("selfloop_fault",   32'(bus.pc_fault), 32'h1);

        do_start(12'h020);
        check("restart_fault", 32'(bus.pc_fault), 32'h0);
        check("restart_done",  32'(bus.done),     32'h0);
        idle_inputs();
        bus.halt_req     = 1'b1;
        bus.branch_en    = 1'b1;
        bus.branch_taken = 1'b1;
        bus.target       = 12'h009;
        tick();
        idle_inputs();
        check("halt_beats_br_pc",   32'(bus.prog_ctr), 32'h020);
        check("halt_beats_br_done", 32'(bus.done),     32'h1);
        do_start(12'h000);
        check("restart0_pc",      32'(bus.prog_ctr),    32'h000);
        check("restart0_count",   32'(bus.instr_count), 32'h0);
        check("restart0_fault",   32'(bus.pc_fault),    32'h0);
        check("restart0_running", 32'(bus.running),     32'h1);

        // Asynchronous reset mid-run, checked between clock edges
        do_branch(1'b1, 1'b1, 12'h055);
        check("pre_rst_pc", 32'(bus.prog_ctr), 32'h055);
        #1;
        Reset = 1'b1;
        #1;
        check("async_rst_pc",      32'(bus.prog_ctr),    32'h000);
        check("async_rst_running", 32'(bus.running),     32'h0);
        check("async_rst_count",   32'(bus.instr_count), 32'h0);
        tick();
        Reset = 1'b0;
        do_start(12'h030);
        tick();
        check("post_rst_pc",      32'(bus.prog_ctr), 32'h031);
        check("post_rst_running", 32'(bus.running),  32'h1);

        // Start ignored in RUN; sequential wrap at the top of the address space
        do_halt();
        do_start(12'hFFE);
        bus.start      = 1'b1;
        bus.start_addr = 12'h123;
        tick();
        idle_inputs();
        check("run_start_ignored", 32'(bus.prog_ctr), 32'hFFF);
        check("pre_wrap_fault",    32'(bus.pc_fault), 32'h0);
        tick();
        check("wrap_pc",      32'(bus.prog_ctr), 32'h000);
        check("wrap_fault",   32'(bus.pc_fault), 32'h1);
        check("wrap_running", 32'(bus.running),  32'h1);
        tick();
        check("fault_sticky", 32'(bus.pc_fault), 32'h1);

        // Counter saturation
        do_halt();
        do_start(12'h000);
        for (int i = 0; i < 65534; i++) begin
            @(posedge Clk);
        end
        #1;
        check("count_fffe", 32'(bus.instr_count), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("count_sat", 32'(bus.instr_count), 32'hFFFF);
        end
        do_halt();
        check("sat_halt_count", 32'(bus.instr_count), 32'hFFFF);
        check("sat_halt_done",  32'(bus.done),        32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
